// File: rtl/ysyx_23060184_exec_ctrl_pkg.sv
// ysyx_23060184_exec_ctrl_pkg
// Shared encodings for the multi-cycle execution controller:
//   - result / ALU-A / ALU-B / next-PC select codes and their widths
//   - RV32 opcode constants used by the class decoder
//   - SYSTEM funct3 and imm[11:0] codes
//   - controller state encoding and instruction class bit positions
package ysyx_23060184_exec_ctrl_pkg;

  localparam int RESULT_SRC_LENGTH = 2;
  localparam int ALU_SRC_A_LENGTH  = 2;
  localparam int ALU_SRC_B_LENGTH  = 2;
  localparam int PC_SRC_LENGTH     = 2;

  localparam logic [RESULT_SRC_LENGTH-1:0] RES_PCPLUS4 = 2'd0;
  localparam logic [RESULT_SRC_LENGTH-1:0] RES_ALU     = 2'd1;
  localparam logic [RESULT_SRC_LENGTH-1:0] RES_MEM     = 2'd2;
  localparam logic [RESULT_SRC_LENGTH-1:0] RES_CSR     = 2'd3;

  localparam logic [ALU_SRC_A_LENGTH-1:0] SRCA_RD1  = 2'd0;
  localparam logic [ALU_SRC_A_LENGTH-1:0] SRCA_PC   = 2'd1;
  localparam logic [ALU_SRC_A_LENGTH-1:0] SRCA_ZERO = 2'd2;

  localparam logic [ALU_SRC_B_LENGTH-1:0] SRCB_RD2  = 2'd0;
  localparam logic [ALU_SRC_B_LENGTH-1:0] SRCB_IMM  = 2'd1;
  localparam logic [ALU_SRC_B_LENGTH-1:0] SRCB_CSR  = 2'd2;
  localparam logic [ALU_SRC_B_LENGTH-1:0] SRCB_ZERO = 2'd3;

  localparam logic [PC_SRC_LENGTH-1:0] PC_PLUS4   = 2'd0;
  localparam logic [PC_SRC_LENGTH-1:0] PC_TARGET  = 2'd1;
  localparam logic [PC_SRC_LENGTH-1:0] PC_ALU     = 2'd2;
  localparam logic [PC_SRC_LENGTH-1:0] PC_CSRREAD = 2'd3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_PRIV  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;
  localparam logic [11:0] IMM_MRET   = 12'h302;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  // Bit positions inside the one-hot class vector.
  localparam int CLS_LUI    = 0;
  localparam int CLS_AUIPC  = 1;
  localparam int CLS_JAL    = 2;
  localparam int CLS_JALR   = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_LOAD   = 5;
  localparam int CLS_STORE  = 6;
  localparam int CLS_OPIMM  = 7;
  localparam int CLS_OP     = 8;
  localparam int CLS_CSRRW  = 9;
  localparam int CLS_CSRRS  = 10;
  localparam int CLS_ECALL  = 11;
  localparam int CLS_EBREAK = 12;
  localparam int CLS_MRET   = 13;
  localparam int CLS_NUM    = 14;

endpackage

// File: rtl/ysyx_23060184_inst_class.sv
// ysyx_23060184_inst_class
// Purely combinational instruction classifier.
//   inst_q  in  32        latched instruction word
//   cls     out CLS_NUM   one-hot class vector (all zero when illegal)
//   illegal out 1         opcode / SYSTEM encoding not supported
module ysyx_23060184_inst_class
  import ysyx_23060184_exec_ctrl_pkg::*;
(
  input  logic [31:0]        inst_q,
  output logic [CLS_NUM-1:0] cls,
  output logic               illegal
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [11:0] imm12;

  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign imm12  = inst_q[31:20];

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI:    cls[CLS_LUI]    = 1'b1;
      OPC_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
      OPC_JAL:    cls[CLS_JAL]    = 1'b1;
      OPC_JALR:   cls[CLS_JALR]   = 1'b1;
      OPC_BRANCH: cls[CLS_BRANCH] = 1'b1;
      OPC_LOAD:   cls[CLS_LOAD]   = 1'b1;
      OPC_STORE:  cls[CLS_STORE]  = 1'b1;
      OPC_OPIMM:  cls[CLS_OPIMM]  = 1'b1;
      OPC_OP:     cls[CLS_OP]     = 1'b1;
      OPC_SYSTEM: begin
        case (funct3)
          F3_CSRRW: cls[CLS_CSRRW] = 1'b1;
          F3_CSRRS: cls[CLS_CSRRS] = 1'b1;
          F3_PRIV: begin
            // Privileged forms carry no register operands; anything else is malformed.
            if (rd == 5'd0 && rs1 == 5'd0) begin
              case (imm12)
                IMM_ECALL:  cls[CLS_ECALL]  = 1'b1;
                IMM_EBREAK: cls[CLS_EBREAK] = 1'b1;
                IMM_MRET:   cls[CLS_MRET]   = 1'b1;
                default:    ;
              endcase
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/ysyx_23060184_exec_ctrl.sv
// ysyx_23060184_exec_ctrl
// Multi-cycle execution controller: IDLE -> FETCH -> EXEC -> [MEM -> [WB]] -> FETCH.
// Owns every architectural write strobe and drives the datapath mux selects.
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req / inst_valid / inst      fetch handshake (instruction latched into inst_q)
//   branch_taken             comparator result, used in EXEC
//   lsu_req / lsu_wen / lsu_done     memory handshake (lsu_wen=1 for stores)
//   inst_q                   latched instruction for decoder / immediate generator
//   alu_src_a/alu_src_b/result_src/pc_src  mux selects, valid in EXEC/MEM/WB only
//   reg_we/csr_we/pc_we/ecall/mret/retire  single-cycle pulses
//   halt, halt_err           sticky stop flags, cleared only by rst
module ysyx_23060184_exec_ctrl
  import ysyx_23060184_exec_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_done,
  output logic [31:0] inst_q,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic        ecall,
  output logic        mret,
  output logic        retire,
  output logic        halt,
  output logic        halt_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // The controller itself never touches data; a datapath narrower than an
  // instruction word is simply not a supported configuration.
  if (DATA_WIDTH < 32) begin : g_narrow_datapath_unsupported
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        inst_d;
  logic               halt_err_q, halt_err_d;

  logic [CLS_NUM-1:0] cls;
  logic               illegal;
  logic [1:0]         a_sel, b_sel, res_sel, pc_sel;
  logic               cls_reg_we, cls_csr_we;

  ysyx_23060184_inst_class u_inst_class (
    .inst_q  (inst_q),
    .cls     (cls),
    .illegal (illegal)
  );

  // Class -> mux selects and per-class write enables.
  always_comb begin
    a_sel      = SRCA_RD1;
    b_sel      = SRCB_RD2;
    res_sel    = RES_ALU;
    pc_sel     = PC_PLUS4;
    cls_reg_we = 1'b0;
    cls_csr_we = 1'b0;
    if (cls[CLS_LUI]) begin
      a_sel = SRCA_ZERO; b_sel = SRCB_IMM; cls_reg_we = 1'b1;
    end else if (cls[CLS_AUIPC]) begin
      a_sel = SRCA_PC; b_sel = SRCB_IMM; cls_reg_we = 1'b1;
    end else if (cls[CLS_JAL]) begin
      a_sel = SRCA_PC; b_sel = SRCB_IMM; res_sel = RES_PCPLUS4; pc_sel = PC_TARGET;
      cls_reg_we = 1'b1;
    end else if (cls[CLS_JALR]) begin
      b_sel = SRCB_IMM; res_sel = RES_PCPLUS4; pc_sel = PC_ALU; cls_reg_we = 1'b1;
    end else if (cls[CLS_BRANCH]) begin
      pc_sel = branch_taken ? PC_TARGET : PC_PLUS4;
    end else if (cls[CLS_LOAD]) begin
      b_sel = SRCB_IMM; res_sel = RES_MEM;
    end else if (cls[CLS_STORE]) begin
      b_sel = SRCB_IMM;
    end else if (cls[CLS_OPIMM]) begin
      b_sel = SRCB_IMM; cls_reg_we = 1'b1;
    end else if (cls[CLS_OP]) begin
      cls_reg_we = 1'b1;
    end else if (cls[CLS_CSRRW]) begin
      a_sel = SRCA_ZERO; b_sel = SRCB_CSR; res_sel = RES_CSR;
      cls_reg_we = 1'b1; cls_csr_we = 1'b1;
    end else if (cls[CLS_CSRRS]) begin
      b_sel = SRCB_CSR; res_sel = RES_CSR; cls_reg_we = 1'b1; cls_csr_we = 1'b1;
    end else if (cls[CLS_ECALL] || cls[CLS_MRET]) begin
      a_sel = SRCA_ZERO; b_sel = SRCB_ZERO; pc_sel = PC_CSRREAD;
    end else if (cls[CLS_EBREAK]) begin
      a_sel = SRCA_ZERO; b_sel = SRCB_ZERO;
    end
  end

  // Next state, timeout counter and output pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    halt_err_d = halt_err_q;
    ifu_req    = 1'b0;
    lsu_req    = 1'b0;
    lsu_wen    = 1'b0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    result_src = '0;
    pc_src     = '0;
    reg_we     = 1'b0;
    csr_we     = 1'b0;
    pc_we      = 1'b0;
    ecall      = 1'b0;
    mret       = 1'b0;
    retire     = 1'b0;

    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_src_a  = a_sel;
      alu_src_b  = b_sel;
      result_src = res_sel;
      pc_src     = pc_sel;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        ifu_req = 1'b1;
        // A handshake on the last allowed cycle takes priority over the timeout.
        if (inst_valid) begin
          inst_d  = inst;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_HALT;
          halt_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (illegal) begin
          state_d    = ST_HALT;
          halt_err_d = 1'b1;
        end else if (cls[CLS_EBREAK]) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
          state_d = ST_MEM;
          cnt_d   = '0;
        end else begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          reg_we  = cls_reg_we;
          csr_we  = cls_csr_we;
          ecall   = cls[CLS_ECALL];
          mret    = cls[CLS_MRET];
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = cls[CLS_STORE];
        if (lsu_done) begin
          if (cls[CLS_STORE]) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = ST_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_HALT;
          halt_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        result_src = RES_MEM;
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
        cnt_d      = '0;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inst_q     <= '0;
      halt_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      halt_err_q <= halt_err_d;
    end
  end

  assign halt     = (state_q == ST_HALT);
  assign halt_err = halt_err_q;

endmodule

// File: tb/tb_ysyx_23060184_exec_ctrl.sv
// Directed self-checking bench for ysyx_23060184_exec_ctrl (TIMEOUT_CYCLES = 8).
module tb_ysyx_23060184_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        ifu_req;
  logic        inst_valid;
  logic [31:0] inst;
  logic        branch_taken;
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_done;
  logic [31:0] inst_q;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic        csr_we;
  logic        pc_we;
  logic        ecall;
  logic        mret;
  logic        retire;
  logic        halt;
  logic        halt_err;

  int checks;
  int errors;

  ysyx_23060184_exec_ctrl #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req      (ifu_req),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .branch_taken (branch_taken),
    .lsu_req      (lsu_req),
    .lsu_wen      (lsu_wen),
    .lsu_done     (lsu_done),
    .inst_q       (inst_q),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .csr_we       (csr_we),
    .pc_we        (pc_we),
    .ecall        (ecall),
    .mret         (mret),
    .retire       (retire),
    .halt         (halt),
    .halt_err     (halt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then step through IDLE so the controller sits in FETCH with a cleared counter.
  task automatic go_fetch;
    inst_valid = 1'b0; lsu_done = 1'b0; branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Present one instruction in FETCH; returns with the controller in EXEC.
  task automatic accept(input logic [31:0] word);
    inst = word;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; inst_valid = 1'b0; lsu_done = 1'b0; branch_taken = 1'b0; inst = 32'h0;
    tick(); tick();
    checks++; if (ifu_req !== 1'b0) begin errors++; $display("FAIL reset_ifu_req got %0h exp 0", ifu_req); end
    checks++; if (inst_q !== 32'h0) begin errors++; $display("FAIL reset_inst_q got %h exp 0", inst_q); end
    checks++; if ({halt, halt_err} !== 2'b00) begin errors++; $display("FAIL reset_halt got %b exp 00", {halt, halt_err}); end
    checks++; if ({lsu_req, retire, pc_we, reg_we} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {lsu_req, retire, pc_we, reg_we}); end
    checks++; if ({alu_src_a, alu_src_b, result_src, pc_src} !== 8'h00) begin errors++; $display("FAIL reset_selects got %h exp 00", {alu_src_a, alu_src_b, result_src, pc_src}); end
    // inst_valid during the IDLE cycle must be ignored.
    rst = 1'b0; inst = 32'h00500093; inst_valid = 1'b1;
    #1;
    checks++; if (ifu_req !== 1'b0) begin errors++; $display("FAIL idle_ifu_req got %0h exp 0", ifu_req); end
    tick();
    inst_valid = 1'b0;
    #1;
    checks++; if (ifu_req !== 1'b1) begin errors++; $display("FAIL fetch_ifu_req got %0h exp 1", ifu_req); end
    checks++; if (inst_q !== 32'h0) begin errors++; $display("FAIL idle_ignore_inst_q got %h exp 0", inst_q); end
    $display("test_reset done");
  endtask

  task automatic test_addi;
    accept(32'h00500093);
    checks++; if (inst_q !== 32'h00500093) begin errors++; $display("FAIL addi_inst_q got %h exp 00500093", inst_q); end
    checks++; if ({alu_src_a, alu_src_b, result_src, pc_src} !== {2'd0, 2'd1, 2'd1, 2'd0}) begin errors++; $display("FAIL addi_selects got %h exp 14", {alu_src_a, alu_src_b, result_src, pc_src}); end
    checks++; if ({reg_we, pc_we, retire, csr_we} !== 4'b1110) begin errors++; $display("FAIL addi_pulses got %b exp 1110", {reg_we, pc_we, retire, csr_we}); end
    tick();
    checks++; if ({ifu_req, retire, reg_we} !== 3'b100) begin errors++; $display("FAIL addi_back_fetch got %b exp 100", {ifu_req, retire, reg_we}); end
    checks++; if (alu_src_b !== 2'd0) begin errors++; $display("FAIL addi_fetch_sel got %0d exp 0", alu_src_b); end
    $display("test_addi inst=00500093");
  endtask

  task automatic test_load;
    accept(32'h0000a103);
    checks++; if ({lsu_req, retire, pc_we, reg_we} !== 4'b0000) begin errors++; $display("FAIL lw_exec got %b exp 0000", {lsu_req, retire, pc_we, reg_we}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) lsu_done = 1'b1;
      #1;
      checks++; if ({lsu_req, lsu_wen, retire, reg_we} !== 4'b1000) begin errors++; $display("FAIL lw_mem%0d got %b exp 1000", i, {lsu_req, lsu_wen, retire, reg_we}); end
    end
    tick();
    lsu_done = 1'b0;
    #1;
    checks++; if (result_src !== 2'd2) begin errors++; $display("FAIL lw_wb_result got %0d exp 2", result_src); end
    checks++; if ({reg_we, pc_we, retire, lsu_req} !== 4'b1110) begin errors++; $display("FAIL lw_wb_pulses got %b exp 1110", {reg_we, pc_we, retire, lsu_req}); end
    tick();
    checks++; if ({ifu_req, retire} !== 2'b10) begin errors++; $display("FAIL lw_after got %b exp 10", {ifu_req, retire}); end
    $display("test_load inst=0000a103");
  endtask

  task automatic test_store;
    accept(32'h0020a023);
    tick();
    lsu_done = 1'b1;
    #1;
    checks++; if ({lsu_req, lsu_wen} !== 2'b11) begin errors++; $display("FAIL sw_mem got %b exp 11", {lsu_req, lsu_wen}); end
    checks++; if ({pc_we, retire, reg_we} !== 3'b110) begin errors++; $display("FAIL sw_done got %b exp 110", {pc_we, retire, reg_we}); end
    tick();
    lsu_done = 1'b0;
    #1;
    checks++; if ({ifu_req, retire, lsu_req} !== 3'b100) begin errors++; $display("FAIL sw_after got %b exp 100", {ifu_req, retire, lsu_req}); end
    $display("test_store inst=0020a023");
  endtask

  task automatic test_branch;
    branch_taken = 1'b1;
    accept(32'h00000463);
    checks++; if (pc_src !== 2'd1) begin errors++; $display("FAIL beq_taken_pc_src got %0d exp 1", pc_src); end
    checks++; if ({reg_we, pc_we, retire} !== 3'b011) begin errors++; $display("FAIL beq_taken_pulses got %b exp 011", {reg_we, pc_we, retire}); end
    tick();
    branch_taken = 1'b0;
    accept(32'h00000463);
    checks++; if (pc_src !== 2'd0) begin errors++; $display("FAIL beq_not_taken_pc_src got %0d exp 0", pc_src); end
    tick();
    $display("test_branch inst=00000463");
  endtask

  task automatic test_jump_sys;
    accept(32'h000100e7);
    checks++; if ({pc_src, result_src} !== {2'd2, 2'd0}) begin errors++; $display("FAIL jalr_sel got %h exp 8", {pc_src, result_src}); end
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL jalr_reg_we got %0h exp 1", reg_we); end
    tick();
    accept(32'h30529073);
    checks++; if ({alu_src_a, alu_src_b, result_src} !== {2'd2, 2'd2, 2'd3}) begin errors++; $display("FAIL csrrw_sel got %h exp 2b", {alu_src_a, alu_src_b, result_src}); end
    checks++; if ({reg_we, csr_we} !== 2'b11) begin errors++; $display("FAIL csrrw_we got %b exp 11", {reg_we, csr_we}); end
    tick();
    accept(32'h00000073);
    checks++; if ({pc_src, ecall, mret, reg_we} !== {2'd3, 3'b100}) begin errors++; $display("FAIL ecall got %b exp 11100", {pc_src, ecall, mret, reg_we}); end
    tick();
    accept(32'h30200073);
    checks++; if ({pc_src, mret, ecall, reg_we} !== {2'd3, 3'b100}) begin errors++; $display("FAIL mret got %b exp 11100", {pc_src, mret, ecall, reg_we}); end
    checks++; if ({pc_we, retire} !== 2'b11) begin errors++; $display("FAIL mret_retire got %b exp 11", {pc_we, retire}); end
    tick();
    checks++; if (mret !== 1'b0) begin errors++; $display("FAIL mret_one_cycle got %0h exp 0", mret); end
    $display("test_jump_sys jalr/csrrw/ecall/mret");
  endtask

  task automatic test_ebreak;
    accept(32'h00100073);
    checks++; if ({retire, pc_we, halt} !== 3'b100) begin errors++; $display("FAIL ebreak_exec got %b exp 100", {retire, pc_we, halt}); end
    tick();
    checks++; if ({halt, halt_err, ifu_req, retire} !== 4'b1000) begin errors++; $display("FAIL ebreak_halt got %b exp 1000", {halt, halt_err, ifu_req, retire}); end
    inst = 32'h00500093; inst_valid = 1'b1;
    tick(); tick();
    inst_valid = 1'b0;
    #1;
    checks++; if ({halt, ifu_req, retire} !== 3'b100) begin errors++; $display("FAIL halt_absorb got %b exp 100", {halt, ifu_req, retire}); end
    checks++; if (inst_q !== 32'h00100073) begin errors++; $display("FAIL halt_inst_q got %h exp 00100073", inst_q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({halt, halt_err} !== 2'b00) begin errors++; $display("FAIL halt_cleared got %b exp 00", {halt, halt_err}); end
    $display("test_ebreak inst=00100073");
  endtask

  task automatic test_timeout;
    go_fetch();
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if ({ifu_req, halt} !== 2'b10) begin errors++; $display("FAIL to_wait%0d got %b exp 10", i, {ifu_req, halt}); end
    end
    // Handshake on the final counted cycle wins over the timeout.
    accept(32'h00500093);
    checks++; if ({halt, retire} !== 2'b01) begin errors++; $display("FAIL to_last_accept got %b exp 01", {halt, retire}); end
    tick();
    for (int i = 1; i < 8; i++) tick();
    checks++; if ({ifu_req, halt} !== 2'b10) begin errors++; $display("FAIL to_before got %b exp 10", {ifu_req, halt}); end
    tick();
    checks++; if ({halt, halt_err, ifu_req} !== 3'b110) begin errors++; $display("FAIL to_halt got %b exp 110", {halt, halt_err, ifu_req}); end
    $display("test_timeout cycles=8");
  endtask

  task automatic test_illegal;
    go_fetch();
    accept(32'h0000007f);
    checks++; if ({retire, pc_we, reg_we, halt} !== 4'b0000) begin errors++; $display("FAIL illegal_exec got %b exp 0000", {retire, pc_we, reg_we, halt}); end
    tick();
    checks++; if ({halt, halt_err, retire} !== 3'b110) begin errors++; $display("FAIL illegal_halt got %b exp 110", {halt, halt_err, retire}); end
    $display("test_illegal inst=0000007f");
  endtask

  task automatic test_reset_mid;
    go_fetch();
    accept(32'h0000a103);
    tick();
    checks++; if (lsu_req !== 1'b1) begin errors++; $display("FAIL mid_mem got %0h exp 1", lsu_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; lsu_done = 1'b1;
    #1;
    checks++; if ({lsu_req, ifu_req, reg_we, retire} !== 4'b0000) begin errors++; $display("FAIL mid_idle got %b exp 0000", {lsu_req, ifu_req, reg_we, retire}); end
    tick();
    lsu_done = 1'b0;
    #1;
    checks++; if ({ifu_req, reg_we, retire} !== 3'b100) begin errors++; $display("FAIL mid_fetch got %b exp 100", {ifu_req, reg_we, retire}); end
    $display("test_reset_mid inst=0000a103");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; inst_valid = 1'b0; inst = 32'h0; branch_taken = 1'b0; lsu_done = 1'b0;
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_jump_sys();
    test_ebreak();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
